// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants for the memory/writeback slice.
package riscv_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [1:0] {
    RS_ALU = 2'b00,
    RS_MEM = 2'b01,
    RS_PC4 = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_fsm_t;

  // Store payload as presented on the data-memory bus.
  typedef struct packed {
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } store_lane_t;

endpackage

// File: rtl/memory_writeback_stage_lsu_align.sv
// Combinational load/store alignment: lane replication, byte enables,
// load extraction/extension and misalignment detection (32-bit only).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic              is_store,
  input  logic              is_load,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] load_word,
  output store_lane_t       store_lane,
  output logic [WORD_W-1:0] load_data,
  output logic              misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicate store data across lanes and place the byte enables.
  always_comb begin
    store_lane.wdata = store_data;
    store_lane.be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_lane.wdata = {4{store_data[7:0]}};
        store_lane.be    = 4'(4'b0001 << addr_lo);
      end
      2'b01: begin
        store_lane.wdata = {2{store_data[15:0]}};
        store_lane.be    = 4'(4'b0011 << addr_lo);
      end
      default: ;
    endcase
  end

  // Select the addressed byte/halfword and extend it.
  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = load_word[7:0];
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = load_word;
    endcase
  end

  // Flag accesses that cannot be issued; unsupported sizes count as misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    misaligned = 1'b0;
        F3_H:    misaligned = addr_lo[0];
        F3_W:    misaligned = |addr_lo;
        default: misaligned = 1'b1;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_B, F3_BU: misaligned = 1'b0;
        F3_H, F3_HU: misaligned = addr_lo[0];
        F3_W:        misaligned = |addr_lo;
        default:     misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// RV32I memory stage: data-memory handshake, stall generation and the
// Memory/Writeback pipeline register.
module memory_writeback_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]       PCPlus4M,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_rdata,
  output logic                  StallM,
  output logic                  MisalignedM,
  output logic                  RegWriteW,
  output logic [XLEN-1:0]       ResultW,
  output logic [REG_ADDR_W-1:0] RdW
);

  mem_fsm_t          state_q;
  mem_fsm_t          state_d;
  logic              is_store;
  logic              is_load;
  logic              mem_op;
  store_lane_t       lane;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   result_c;

  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == RS_MEM);
  assign mem_op   = is_store | is_load;

  lsu_align u_lsu_align (
    .funct3     (Funct3M),
    .addr_lo    (ALUResultM[1:0]),
    .is_store   (is_store),
    .is_load    (is_load),
    .store_data (WriteDataM),
    .load_word  (dmem_rsp_rdata),
    .store_lane (lane),
    .load_data  (load_data),
    .misaligned (MisalignedM)
  );

  assign dmem_addr   = {ALUResultM[XLEN-1:2], 2'b00};
  assign dmem_wdata  = lane.wdata;
  assign dmem_be     = lane.be;
  assign dmem_req_we = is_store;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, request valid and stall; M inputs are frozen while stalled.
  always_comb begin
    state_d        = state_q;
    dmem_req_valid = 1'b0;
    StallM         = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !MisalignedM) begin
          dmem_req_valid = 1'b1;
          if (!dmem_req_ready) begin
            StallM = 1'b1;
          end else if (is_load) begin
            StallM  = 1'b1;
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) state_d = IDLE;
        else                StallM  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback result select; reserved encoding falls back to the ALU result.
  always_comb begin
    case (result_src_t'(ResultSrcM))
      RS_MEM:  result_c = load_data;
      RS_PC4:  result_c = PCPlus4M;
      default: result_c = ALUResultM;
    endcase
  end

  // M/W pipeline register; a stall retires a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      ResultW   <= '0;
      RdW       <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~MisalignedM & (RdM != '0);
      RdW       <= RdM;
      ResultW   <= result_c;
    end
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Randomized self-checking bench for memory_writeback_stage.
module tb_memory_writeback_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        StallM;
  logic        MisalignedM;
  logic        RegWriteW;
  logic [31:0] ResultW;
  logic [4:0]  RdW;

  memory_writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .StallM(StallM), .MisalignedM(MisalignedM),
    .RegWriteW(RegWriteW), .ResultW(ResultW), .RdW(RdW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model expectations for the current cycle and the W register.
  logic        exp_req, exp_stall, exp_mis, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_rw;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;

  int          knob_ready_delay = -1;
  int          knob_rsp_delay   = -1;
  bit          knob_rdata_fix   = 1'b0;
  logic [31:0] knob_rdata       = 32'd0;
  int          last_nstall, last_nreq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_mis(input bit st, input logic [2:0] f3, input logic [1:0] a);
    int sz;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    return 1'b1;
    endcase
    if (st && f3[2]) return 1'b1;
    return (int'(a) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
    int m;
    case (f3)
      3'd0:    m = 1 << int'(a);
      3'd1:    m = 3 << int'(a);
      default: m = 15;
    endcase
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * int'(a));
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (ResultSrcM)
      2'b01:   return ref_load(Funct3M, ALUResultM[1:0], dmem_rsp_rdata);
      2'b10:   return PCPlus4M;
      default: return ALUResultM;
    endcase
  endfunction

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("req_valid", 32'(dmem_req_valid), 32'(exp_req));
      chk("stall", 32'(StallM), 32'(exp_stall));
      chk("misaligned", 32'(MisalignedM), 32'(exp_mis));
      if (exp_req) begin
        chk("req_addr", dmem_addr, exp_addr);
        chk("req_we", 32'(dmem_req_we), 32'(exp_we));
        if (exp_we) begin
          chk("req_wdata", dmem_wdata, exp_wdata);
          chk("req_be", 32'(dmem_be), 32'(exp_be));
        end
      end
      chk("regwrite_w", 32'(RegWriteW), 32'(exp_rw));
      chk("result_w", ResultW, exp_res);
      chk("rd_w", 32'(RdW), 32'(exp_rd));
    end
  end

  task automatic set_instr(input bit rw, input logic [1:0] rs, input bit mw, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] pc4);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
  endtask

  // Hold the current M instruction until the model says it retires.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_instr();
    bit acc, done, st, ld, mem;
    int waited, lat, cyc;
    acc = 1'b0; done = 1'b0; waited = 0; cyc = 0;
    last_nstall = 0; last_nreq = 0;
    lat = (knob_rsp_delay < 0) ? int'($urandom_range(0, 3)) : knob_rsp_delay;
    st  = MemWriteM;
    ld  = !MemWriteM && (ResultSrcM == 2'b01);
    mem = st || ld;
    exp_mis   = mem && ref_mis(st, Funct3M, ALUResultM[1:0]);
    exp_addr  = {ALUResultM[31:2], 2'b00};
    exp_we    = st;
    exp_wdata = ref_wdata(Funct3M, WriteDataM);
    exp_be    = ref_be(Funct3M, ALUResultM[1:0]);
    while (!done) begin
      if (!acc) dmem_req_ready = (knob_ready_delay < 0) ? ($urandom_range(0, 2) != 0)
                                                        : (waited >= knob_ready_delay);
      else      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = acc ? (lat == 0) : ($urandom_range(0, 3) == 0);
      dmem_rsp_rdata = knob_rdata_fix ? knob_rdata : $urandom;
      if (!mem || exp_mis) begin exp_req = 1'b0; exp_stall = 1'b0; end
      else if (st)         begin exp_req = 1'b1; exp_stall = !dmem_req_ready; end
      else if (!acc)       begin exp_req = 1'b1; exp_stall = 1'b1; end
      else                 begin exp_req = 1'b0; exp_stall = !dmem_rsp_valid; end
      @(negedge clk);
      if (StallM) last_nstall++;
      if (dmem_req_valid) last_nreq++;
      @(posedge clk);
      if (exp_stall) exp_rw = 1'b0;
      else begin
        exp_rw  = RegWriteM && !exp_mis && (RdM != 5'd0);
        exp_rd  = RdM;
        exp_res = ref_result();
      end
      if (!exp_stall)      done = 1'b1;
      else if (acc)        lat--;
      else if (ld && dmem_req_ready) acc = 1'b1;
      else                 waited++;
      cyc++;
      if (!done && cyc > 60) begin
        checks++; errors++;
        $display("FAIL timeout instruction did not retire within 60 cycles t=%0t", $time);
        done = 1'b1;
      end
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regwrite_w", 32'(RegWriteW), 32'd0);
    chk("reset_result_w", ResultW, 32'd0);
    chk("reset_rd_w", 32'(RdW), 32'd0);
    chk("reset_req_valid", 32'(dmem_req_valid), 32'd0);
    rst_n = 1'b1;
    exp_rw = 1'b0; exp_res = 32'd0; exp_rd = 5'd0;
    cmp_en = 1'b1;

    // ALU pass-through
    set_instr(1'b1, 2'b00, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 32'h2000);
    run_instr();
    chk("alu_regwrite", 32'(RegWriteW), 32'd1);
    chk("alu_result", ResultW, 32'h0000_1234);
    chk("alu_rd", 32'(RdW), 32'd5);
    chk("alu_stall_cycles", 32'(last_nstall), 32'd0);

    // SB to byte lane 3, accepted immediately
    set_instr(1'b0, 2'b00, 1'b1, F3_B, 32'h103, 32'hAB, 5'd0, 32'd0);
    dmem_req_ready = 1'b1;
    #1;
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_be", 32'(dmem_be), 32'h8);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_we", 32'(dmem_req_we), 32'd1);
    chk("sb_stall", 32'(StallM), 32'd0);
    knob_ready_delay = 0;
    run_instr();

    // LB / LBU with response one wait cycle after acceptance
    knob_rsp_delay = 1; knob_rdata_fix = 1'b1; knob_rdata = 32'h0080_0000;
    set_instr(1'b1, 2'b01, 1'b0, F3_B, 32'h102, 32'd0, 5'd7, 32'd0);
    run_instr();
    chk("lb_stall_cycles", 32'(last_nstall), 32'd2);
    chk("lb_result", ResultW, 32'hFFFF_FF80);
    chk("lb_regwrite", 32'(RegWriteW), 32'd1);
    set_instr(1'b1, 2'b01, 1'b0, F3_BU, 32'h102, 32'd0, 5'd7, 32'd0);
    run_instr();
    chk("lbu_result", ResultW, 32'h0000_0080);

    // LW held off by three not-ready cycles
    knob_ready_delay = 3; knob_rsp_delay = 0; knob_rdata = 32'hCAFE_F00D;
    set_instr(1'b1, 2'b01, 1'b0, F3_W, 32'h200, 32'd0, 5'd9, 32'd0);
    run_instr();
    chk("lw_req_cycles", 32'(last_nreq), 32'd4);
    chk("lw_stall_cycles", 32'(last_nstall), 32'd4);
    chk("lw_result", ResultW, 32'hCAFE_F00D);

    // Misaligned LH
    knob_ready_delay = 0;
    set_instr(1'b1, 2'b01, 1'b0, F3_H, 32'h101, 32'd0, 5'd4, 32'd0);
    #1;
    chk("lh_mis_flag", 32'(MisalignedM), 32'd1);
    chk("lh_mis_req", 32'(dmem_req_valid), 32'd0);
    chk("lh_mis_stall", 32'(StallM), 32'd0);
    run_instr();
    chk("lh_mis_regwrite", 32'(RegWriteW), 32'd0);

    // Reset while waiting for a load response, then a stray response
    knob_rdata_fix = 1'b0; knob_rsp_delay = -1;
    set_instr(1'b1, 2'b00, 1'b0, 3'd0, 32'h5A5A, 32'd0, 5'd3, 32'd0);
    run_instr();
    cmp_en = 1'b0;
    set_instr(1'b1, 2'b01, 1'b0, F3_W, 32'h300, 32'd0, 5'd6, 32'd0);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    @(posedge clk);
    #2;
    dmem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_regwrite_w", 32'(RegWriteW), 32'd0);
    chk("rst_mid_result_w", ResultW, 32'd0);
    chk("rst_mid_rd_w", 32'(RdW), 32'd0);
    chk("rst_mid_idle_req", 32'(dmem_req_valid), 32'd1);
    #1;
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1357_9BDF;
    #1;
    chk("stray_rsp_stall", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    chk("stray_rsp_regwrite", 32'(RegWriteW), 32'd0);
    chk("stray_rsp_result", ResultW, 32'd0);
    exp_rw = 1'b0; exp_res = 32'd0; exp_rd = 5'd0;
    cmp_en = 1'b1;
    knob_ready_delay = -1;
    run_instr();

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [2:0] f3;
      logic [1:0] rs;
      bit mw;
      logic [2:0] ld_f3 [5];
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
      kind = int'($urandom_range(0, 9));
      mw = 1'b0; f3 = 3'($urandom_range(0, 7));
      if (kind == 0)      rs = 2'b00;
      else if (kind == 1) rs = 2'b10;
      else if (kind == 2) rs = 2'b11;
      else if (kind < 7) begin
        rs = 2'b01;
        f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        rs = 2'b00; mw = 1'b1;
        f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      end
      set_instr(($urandom_range(0, 3) != 0), rs, mw, f3, $urandom, $urandom,
                5'($urandom_range(0, 31)), $urandom);
      run_instr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
